shield_hit_ctrl: RTL and testbench

SHIELD_HIT_CTRL -- requirements
Module: shield_hit_ctrl

---
 rtl/shield_hit_ctrl_pkg.sv | 12 +
 rtl/shield_hit_latch.sv | 81 ++++++++
 rtl/shield_hit_ctrl.sv | 70 +++++++
 tb/tb_shield_hit_ctrl.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/shield_hit_ctrl_pkg.sv
// Shared types and constants for the shield hit controller.
package shield_hit_ctrl_pkg;

  localparam int unsigned COORD_W = 11;

  typedef enum logic [1:0] {
    EMPTY   = 2'd0,
    LATCHED = 2'd1,
    ERASE   = 2'd2
  } hit_state_t;

endpackage

// File: rtl/shield_hit_latch.sv
// One projectile source: remembers its first shield hit of a frame, issues the
// kill at the next frame start, then erases the shield pixel when it is rescanned.
module shield_hit_latch
  import shield_hit_ctrl_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic               start_of_frame,
  input  logic               play_game,
  input  logic [COORD_W-1:0] pixel_x,
  input  logic [COORD_W-1:0] pixel_y,
  input  logic               shield_draw_req,
  input  logic               source_draw_req,
  output logic               kill,
  output logic               erase_req
);

  hit_state_t         state;
  hit_state_t         state_next;
  logic [COORD_W-1:0] hit_x;
  logic [COORD_W-1:0] hit_y;
  logic               capture;
  logic               hit;
  logic               match;

  assign hit   = shield_draw_req & source_draw_req;
  assign match = (pixel_x == hit_x) && (pixel_y == hit_y);

  // Outputs are masked by reset so a pending erase is dropped, not strobed.
  always_comb begin
    state_next = state;
    kill       = 1'b0;
    erase_req  = 1'b0;
    capture    = 1'b0;
    if (!play_game) begin
      state_next = EMPTY;
    end else begin
      case (state)
        EMPTY: begin
          if (hit) begin
            state_next = LATCHED;
            capture    = 1'b1;
          end
        end
        LATCHED: begin
          if (start_of_frame) begin
            state_next = ERASE;
            kill       = ~reset;
          end
        end
        ERASE: begin
          if (match) begin
            state_next = EMPTY;
            erase_req  = ~reset;
          end else if (start_of_frame) begin
            state_next = EMPTY;
          end
        end
        default: state_next = EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= EMPTY;
      hit_x <= '0;
      hit_y <= '0;
    end else begin
      state <= state_next;
      if (!play_game) begin
        hit_x <= '0;
        hit_y <= '0;
      end else if (capture) begin
        hit_x <= pixel_x;
        hit_y <= pixel_y;
      end
    end
  end

endmodule

// File: rtl/shield_hit_ctrl.sv
// Shield damage controller: missile (and, with SHIELD_BOMB_HIT_EN defined, bomb)
// hit tracking, shield erase strobe and saturating hit counter.
module shield_hit_ctrl
  import shield_hit_ctrl_pkg::*;
#(
  parameter int unsigned HIT_CNT_W = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 startOfFrame,
  input  logic                 playGame,
  input  logic [COORD_W-1:0]   pixelX,
  input  logic [COORD_W-1:0]   pixelY,
  input  logic                 shieldDrawReq,
  input  logic                 missileDrawReq,
  input  logic                 bombDrawReq,
  output logic                 shieldCollision,
  output logic                 missileKill,
  output logic                 bombKill,
  output logic [HIT_CNT_W-1:0] hitCount
);

  logic missile_erase;
  logic bomb_erase;

  shield_hit_latch u_missile (
    .clk             (clk),
    .reset           (reset),
    .start_of_frame  (startOfFrame),
    .play_game       (playGame),
    .pixel_x         (pixelX),
    .pixel_y         (pixelY),
    .shield_draw_req (shieldDrawReq),
    .source_draw_req (missileDrawReq),
    .kill            (missileKill),
    .erase_req       (missile_erase)
  );

`ifdef SHIELD_BOMB_HIT_EN
  shield_hit_latch u_bomb (
    .clk             (clk),
    .reset           (reset),
    .start_of_frame  (startOfFrame),
    .play_game       (playGame),
    .pixel_x         (pixelX),
    .pixel_y         (pixelY),
    .shield_draw_req (shieldDrawReq),
    .source_draw_req (bombDrawReq),
    .kill            (bombKill),
    .erase_req       (bomb_erase)
  );
`else
  logic bomb_req_unused;
  assign bomb_req_unused = bombDrawReq;
  assign bombKill        = 1'b0;
  assign bomb_erase      = 1'b0;
`endif

  // A shared pixel erased by both sources collapses into one strobe and one count.
  assign shieldCollision = missile_erase | bomb_erase;

  always_ff @(posedge clk) begin
    if (reset || !playGame) begin
      hitCount <= '0;
    end else if (shieldCollision && (hitCount != '1)) begin
      hitCount <= hitCount + HIT_CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_shield_hit_ctrl.sv
// Directed bench for shield_hit_ctrl with a narrow hit counter to reach saturation.
module tb_shield_hit_ctrl;

  localparam int unsigned CW = 3;

  logic          clk = 1'b0;
  logic          reset;
  logic          startOfFrame;
  logic          playGame;
  logic [10:0]   pixelX;
  logic [10:0]   pixelY;
  logic          shieldDrawReq;
  logic          missileDrawReq;
  logic          bombDrawReq;
  logic          shieldCollision;
  logic          missileKill;
  logic          bombKill;
  logic [CW-1:0] hitCount;

  int   checks = 0;
  int   errors = 0;
  int   col_total = 0;
  logic s_col;
  logic s_mk;
  logic s_bk;

  always #5 clk = ~clk;

  shield_hit_ctrl #(.HIT_CNT_W(CW)) dut (
    .clk             (clk),
    .reset           (reset),
    .startOfFrame    (startOfFrame),
    .playGame        (playGame),
    .pixelX          (pixelX),
    .pixelY          (pixelY),
    .shieldDrawReq   (shieldDrawReq),
    .missileDrawReq  (missileDrawReq),
    .bombDrawReq     (bombDrawReq),
    .shieldCollision (shieldCollision),
    .missileKill     (missileKill),
    .bombKill        (bombKill),
    .hitCount        (hitCount)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One clock cycle: apply inputs, sample combinational outputs mid-cycle, step past the edge.
  task automatic cyc(input logic sof, input logic sh, input logic mi, input logic bo,
                     input logic [10:0] x, input logic [10:0] y);
    startOfFrame   = sof;
    shieldDrawReq  = sh;
    missileDrawReq = mi;
    bombDrawReq    = bo;
    pixelX         = x;
    pixelY         = y;
    #2;
    s_col = shieldCollision;
    s_mk  = missileKill;
    s_bk  = bombKill;
    if (shieldCollision === 1'b1) col_total++;
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1; playGame = 1'b1;
    startOfFrame = 1'b0; shieldDrawReq = 1'b0; missileDrawReq = 1'b0; bombDrawReq = 1'b0;
    pixelX = '0; pixelY = '0;
    @(posedge clk); #1;

    // Reset dominates active hit inputs
    cyc(1, 1, 1, 1, 5, 5);
    chk("rst_col", 32'(s_col), 0);
    chk("rst_mk", 32'(s_mk), 0);
    chk("rst_bk", 32'(s_bk), 0);
    chk("rst_cnt", 32'(hitCount), 0);
    cyc(0, 1, 1, 1, 5, 5);
    reset = 1'b0;
    cyc(1, 0, 0, 0, 0, 0);
    chk("rst_nolatch_mk", 32'(s_mk), 0);

    // Basic hit at (200,400), erase next frame
    cyc(1, 0, 0, 0, 0, 0);
    cyc(0, 1, 1, 0, 200, 400);
    chk("b_hit_mk", 32'(s_mk), 0);
    chk("b_hit_col", 32'(s_col), 0);
    cyc(0, 0, 0, 0, 201, 400);
    cyc(1, 0, 0, 0, 0, 0);
    chk("b_sof_mk", 32'(s_mk), 1);
    chk("b_sof_col", 32'(s_col), 0);
    col_total = 0;
    cyc(0, 1, 0, 0, 199, 400);
    chk("b_mk_pulse", 32'(s_mk), 0);
    chk("b_col_199", 32'(s_col), 0);
    cyc(0, 1, 0, 0, 200, 400);
    chk("b_col_200", 32'(s_col), 1);
    chk("b_cnt", 32'(hitCount), 1);
    cyc(0, 1, 0, 0, 200, 400);
    chk("b_col_once", 32'(s_col), 0);
    chk("b_col_total", 32'(col_total), 1);

    // Only the first hit in a frame is kept
    cyc(1, 0, 0, 0, 0, 0);
    cyc(0, 1, 1, 0, 200, 400);
    cyc(0, 1, 1, 0, 201, 400);
    cyc(1, 0, 0, 0, 0, 0);
    chk("f_sof_mk", 32'(s_mk), 1);
    col_total = 0;
    cyc(0, 0, 0, 0, 201, 400);
    chk("f_col_201", 32'(s_col), 0);
    cyc(0, 0, 0, 0, 200, 400);
    chk("f_col_200", 32'(s_col), 1);
    chk("f_cnt", 32'(hitCount), 2);
    chk("f_col_total", 32'(col_total), 1);

    // Hit pixel never rescanned: abandoned at next frame start
    cyc(0, 1, 1, 0, 200, 400);
    cyc(1, 0, 0, 0, 0, 0);
    chk("s_sof_mk", 32'(s_mk), 1);
    col_total = 0;
    cyc(0, 0, 0, 0, 100, 100);
    cyc(1, 0, 0, 0, 0, 0);
    chk("s_sof2_mk", 32'(s_mk), 0);
    cyc(0, 0, 0, 0, 200, 400);
    chk("s_col_late", 32'(s_col), 0);
    chk("s_col_total", 32'(col_total), 0);
    chk("s_cnt", 32'(hitCount), 2);
    cyc(0, 1, 1, 0, 7, 8);
    cyc(1, 0, 0, 0, 0, 0);
    chk("s_relatch_mk", 32'(s_mk), 1);
    cyc(0, 0, 0, 0, 7, 8);
    chk("s_relatch_col", 32'(s_col), 1);
    chk("s_relatch_cnt", 32'(hitCount), 3);

    // Hit coincident with startOfFrame: kill deferred one frame
    cyc(1, 1, 1, 0, 50, 60);
    chk("c_same_mk", 32'(s_mk), 0);
    cyc(0, 0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 0);
    chk("c_next_mk", 32'(s_mk), 1);
    cyc(0, 0, 0, 0, 50, 60);
    chk("c_col", 32'(s_col), 1);
    chk("c_cnt", 32'(hitCount), 4);

    // playGame drop while in ERASE
    cyc(0, 1, 1, 0, 10, 20);
    cyc(1, 0, 0, 0, 0, 0);
    chk("p_sof_mk", 32'(s_mk), 1);
    playGame = 1'b0;
    cyc(0, 0, 0, 0, 10, 20);
    chk("p_low_col", 32'(s_col), 0);
    chk("p_low_mk", 32'(s_mk), 0);
    chk("p_low_cnt", 32'(hitCount), 0);
    playGame = 1'b1;
    cyc(0, 0, 0, 0, 10, 20);
    chk("p_after_col", 32'(s_col), 0);
    playGame = 1'b0;
    cyc(0, 1, 1, 0, 11, 22);
    playGame = 1'b1;
    cyc(1, 0, 0, 0, 0, 0);
    chk("p_nolatch_mk", 32'(s_mk), 0);

    // Reset while LATCHED
    cyc(0, 1, 1, 0, 30, 40);
    cyc(1, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 30, 40);
    chk("r_pre_cnt", 32'(hitCount), 1);
    cyc(0, 1, 1, 0, 31, 41);
    reset = 1'b1;
    cyc(0, 0, 0, 0, 0, 0);
    reset = 1'b0;
    chk("r_cnt", 32'(hitCount), 0);
    cyc(1, 0, 0, 0, 0, 0);
    chk("r_sof_mk", 32'(s_mk), 0);
    cyc(0, 0, 0, 0, 31, 41);
    chk("r_col", 32'(s_col), 0);

    // Reset while ERASE at the matching pixel
    cyc(0, 1, 1, 0, 60, 70);
    cyc(1, 0, 0, 0, 0, 0);
    chk("e_sof_mk", 32'(s_mk), 1);
    reset = 1'b1;
    cyc(0, 0, 0, 0, 60, 70);
    chk("e_rst_col", 32'(s_col), 0);
    reset = 1'b0;
    cyc(0, 0, 0, 0, 60, 70);
    chk("e_after_col", 32'(s_col), 0);
    chk("e_cnt", 32'(hitCount), 0);

    // Counter saturation at all-ones
    for (int i = 0; i < 9; i++) begin
      cyc(0, 1, 1, 0, 11'(i + 1), 5);
      cyc(1, 0, 0, 0, 0, 0);
      cyc(0, 0, 0, 0, 11'(i + 1), 5);
      chk("sat_col", 32'(s_col), 1);
      chk("sat_cnt", 32'(hitCount), (i < 7) ? 32'(i + 1) : 32'd7);
    end

    playGame = 1'b0;
    cyc(0, 0, 0, 0, 0, 0);
    playGame = 1'b1;
    chk("clr_cnt", 32'(hitCount), 0);

`ifdef SHIELD_BOMB_HIT_EN
    // Missile and bomb hit the same pixel
    cyc(0, 1, 1, 1, 300, 420);
    cyc(1, 0, 0, 0, 0, 0);
    chk("mb_mk", 32'(s_mk), 1);
    chk("mb_bk", 32'(s_bk), 1);
    col_total = 0;
    cyc(0, 0, 0, 0, 300, 420);
    chk("mb_col", 32'(s_col), 1);
    cyc(0, 0, 0, 0, 300, 420);
    chk("mb_col_once", 32'(s_col), 0);
    chk("mb_cnt", 32'(hitCount), 1);
    chk("mb_col_total", 32'(col_total), 1);
`else
    // Bomb ignored when bomb tracking is compiled out
    cyc(0, 1, 0, 1, 250, 410);
    cyc(1, 0, 0, 0, 0, 0);
    chk("nb_bk", 32'(s_bk), 0);
    chk("nb_mk", 32'(s_mk), 0);
    col_total = 0;
    cyc(0, 0, 0, 0, 250, 410);
    chk("nb_col", 32'(s_col), 0);
    chk("nb_cnt", 32'(hitCount), 0);
    chk("nb_col_total", 32'(col_total), 0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
